// File: rtl/mem_rmw_controller.sv
// Byte-masked load/store front end for a word-wide synchronous RAM.
// Sub-word stores become read-modify-write sequences. One request is in flight at a time, and req is sampled only in IDLE.
module mem_rmw_controller #(
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  input  logic                  wr_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [3:0]            data_mask_bus_i,
  input  logic [31:0]           data_bus_i,
  output logic                  ack_o,
  output logic                  err_o,
  output logic [31:0]           data_out_o,
  output logic [ADDR_WIDTH-3:0] mem_addr_o,
  output logic                  mem_rd_en_o,
  input  logic [31:0]           mem_rd_data_i,
  output logic                  mem_wr_en_o,
  output logic [31:0]           mem_wr_data_o
);

  localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_ACK
  } state_t;

  state_t                state_q;
  logic                  wr_q;
  logic [1:0]            off_q;
  logic [3:0]            mask_q;
  logic [31:0]           data_q;
  logic [CW-1:0]         cnt_q;
  logic                  ack_q;
  logic                  err_q;
  logic                  rd_en_q;
  logic                  wr_en_q;
  logic [31:0]           data_out_q;
  logic [31:0]           wr_data_q;
  logic [ADDR_WIDTH-3:0] mem_addr_q;

  logic [6:0]            smask_full;
  logic [31:0]           lane_mask;
  logic [31:0]           data_shifted;
  logic [31:0]           wr_data_d;
  logic [31:0]           data_out_d;
  logic                  err_d;

  function automatic logic [31:0] byte_expand(input logic [3:0] m);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = {8{m[i]}};
    end
    return r;
  endfunction

  // Mask bits shifted beyond lane 3 flag err; only the in-range lanes are merged or returned.
  always_comb begin
    smask_full   = {3'b000, mask_q} << off_q;
    lane_mask    = byte_expand(smask_full[3:0]);
    data_shifted = data_q << {off_q, 3'b000};
    wr_data_d    = (mem_rd_data_i & ~lane_mask) | (data_shifted & lane_mask);
    data_out_d   = (mem_rd_data_i >> {off_q, 3'b000}) & byte_expand(mask_q);
    err_d        = |smask_full[6:4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_q       <= 1'b0;
      off_q      <= '0;
      mask_q     <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      data_out_q <= '0;
      wr_data_q  <= '0;
      mem_addr_q <= '0;
    end else begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_i) begin
            wr_q   <= wr_i;
            off_q  <= addr_i[1:0];
            mask_q <= data_mask_bus_i;
            data_q <= data_bus_i;
            if (wr_i && data_mask_bus_i == 4'h0) begin
              state_q <= S_ACK;
              ack_q   <= 1'b1;
            end else if (wr_i && addr_i[1:0] == 2'b00 && data_mask_bus_i == 4'hF) begin
              state_q    <= S_WRITE;
              wr_en_q    <= 1'b1;
              wr_data_q  <= data_bus_i;
              mem_addr_q <= addr_i[ADDR_WIDTH-1:2];
            end else begin
              state_q    <= S_READ;
              rd_en_q    <= 1'b1;
              mem_addr_q <= addr_i[ADDR_WIDTH-1:2];
            end
          end
        end
        S_READ: begin
          state_q <= S_WAIT;
          cnt_q   <= CW'(READ_LATENCY - 1);
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            if (wr_q) begin
              state_q   <= S_WRITE;
              wr_en_q   <= 1'b1;
              wr_data_q <= wr_data_d;
            end else begin
              state_q    <= S_ACK;
              ack_q      <= 1'b1;
              err_q      <= err_d;
              data_out_q <= data_out_d;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_WRITE: begin
          state_q <= S_ACK;
          ack_q   <= 1'b1;
          err_q   <= err_d;
        end
        S_ACK: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ack_o         = ack_q;
  assign err_o         = err_q;
  assign data_out_o    = data_out_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_rd_en_o   = rd_en_q;
  assign mem_wr_en_o   = wr_en_q;
  assign mem_wr_data_o = wr_data_q;

endmodule

// File: tb/tb_mem_rmw_controller.sv
// Bench for mem_rmw_controller: two instances (READ_LATENCY 1 and 3) in front of behavioural RAMs,
// checked against a byte-lane reference model.
module tb_mem_rmw_controller;
  localparam int RL0 = 1;
  localparam int RL1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [1:0]       req, wr, ack, err, rd_en, wr_en;
  logic [1:0][31:0] addr, dbus, dout, rd_data, wr_data;
  logic [1:0][3:0]  mask;
  logic [1:0][29:0] maddr;

  int errors = 0;
  int checks = 0;
  logic [31:0] gold [2][64];
  logic [31:0] last_load [2];

  logic [31:0] ram0 [64];
  logic [31:0] ram1 [64];
  logic [31:0] p0;
  logic [31:0] p1 [3];
  logic        pl_vld = 1'b0;
  logic        pl_g;
  logic [5:0]  pl_idx;
  logic [31:0] pl_dat;

  mem_rmw_controller #(.ADDR_WIDTH(32), .READ_LATENCY(RL0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_i(req[0]), .wr_i(wr[0]), .addr_i(addr[0]),
    .data_mask_bus_i(mask[0]), .data_bus_i(dbus[0]), .ack_o(ack[0]), .err_o(err[0]),
    .data_out_o(dout[0]), .mem_addr_o(maddr[0]), .mem_rd_en_o(rd_en[0]),
    .mem_rd_data_i(rd_data[0]), .mem_wr_en_o(wr_en[0]), .mem_wr_data_o(wr_data[0])
  );

  mem_rmw_controller #(.ADDR_WIDTH(32), .READ_LATENCY(RL1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_i(req[1]), .wr_i(wr[1]), .addr_i(addr[1]),
    .data_mask_bus_i(mask[1]), .data_bus_i(dbus[1]), .ack_o(ack[1]), .err_o(err[1]),
    .data_out_o(dout[1]), .mem_addr_o(maddr[1]), .mem_rd_en_o(rd_en[1]),
    .mem_rd_data_i(rd_data[1]), .mem_wr_en_o(wr_en[1]), .mem_wr_data_o(wr_data[1])
  );

  // Synchronous RAMs: data valid READ_LATENCY cycles after the read strobe.
  always @(posedge clk) begin
    if (pl_vld) begin
      if (pl_g) ram1[pl_idx] <= pl_dat;
      else      ram0[pl_idx] <= pl_dat;
    end
    if (wr_en[0]) ram0[maddr[0][5:0]] <= wr_data[0];
    if (wr_en[1]) ram1[maddr[1][5:0]] <= wr_data[1];
    if (rd_en[0]) p0 <= ram0[maddr[0][5:0]];
    if (rd_en[1]) p1[0] <= ram1[maddr[1][5:0]];
    p1[1] <= p1[0];
    p1[2] <= p1[1];
  end
  assign rd_data[0] = p0;
  assign rd_data[1] = p1[2];

  function automatic logic [31:0] ram_word(input int g, input int idx);
    return (g == 1) ? ram1[idx] : ram0[idx];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int g, input int idx, input logic [31:0] v);
    pl_g   = g[0];
    pl_idx = idx[5:0];
    pl_dat = v;
    pl_vld = 1'b1;
    @(posedge clk);
    #1 pl_vld = 1'b0;
    gold[g][idx] = v;
  endtask

  // Called one time unit after a rising edge; skip=1 when the DUT is still in its ACK cycle.
  task automatic run_txn(input string nm, input int g, input logic w, input logic [31:0] a,
                         input logic [3:0] m, input logic [31:0] d, input int skip, input bit keep);
    int off, idx, rl, el, cyc, rdn, wrn, both, abad, wrcyc;
    logic [31:0] oldv, newv, exp_dout, wdat;
    logic exp_err, got;
    off = int'(a[1:0]);
    idx = int'(a[7:2]);
    rl  = (g == 1) ? RL1 : RL0;
    oldv = gold[g][idx];
    newv = oldv;
    exp_dout = '0;
    exp_err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        if (i + off < 4) begin
          if (w) newv[8*(i+off) +: 8] = d[8*i +: 8];
          else   exp_dout[8*i +: 8] = oldv[8*(i+off) +: 8];
        end else begin
          exp_err = 1'b1;
        end
      end
    end
    if (w && m == 4'h0)                     el = 1;
    else if (w && off == 0 && m == 4'hF)    el = 2;
    else if (!w)                            el = 2 + rl;
    else                                    el = 3 + rl;

    req[g] = 1'b1; wr[g] = w; addr[g] = a; mask[g] = m; dbus[g] = d;
    cyc = 0; rdn = 0; wrn = 0; both = 0; abad = 0; wrcyc = 0; wdat = '0; got = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (rd_en[g]) rdn++;
      if (wr_en[g]) begin wrn++; wrcyc = cyc; wdat = wr_data[g]; end
      if (rd_en[g] && wr_en[g]) both++;
      if ((rd_en[g] || wr_en[g]) && maddr[g] !== a[31:2]) abad++;
      if (ack[g]) got = 1'b1;
    end
    check({nm, "/ack_seen"}, 32'(got), 32'd1);
    check({nm, "/latency"}, 32'(cyc - skip), 32'(el));
    check({nm, "/err"}, 32'(err[g]), 32'(exp_err));
    check({nm, "/data_out"}, dout[g], w ? last_load[g] : exp_dout);
    check({nm, "/rd_strobes"}, 32'(rdn), (!w || el == 3 + rl) ? 32'd1 : 32'd0);
    check({nm, "/wr_strobes"}, 32'(wrn), (w && m != 4'h0) ? 32'd1 : 32'd0);
    check({nm, "/rd_wr_overlap"}, 32'(both), 32'd0);
    check({nm, "/mem_addr"}, 32'(abad), 32'd0);
    if (w && m != 4'h0) begin
      check({nm, "/wr_data"}, wdat, newv);
      check({nm, "/wr_cycle"}, 32'(wrcyc - skip), 32'(el - 1));
    end
    check({nm, "/ram"}, ram_word(g, idx), newv);
    gold[g][idx] = newv;
    if (!w) last_load[g] = exp_dout;
    if (!keep) begin
      req[g] = 1'b0;
      @(posedge clk);
      #1;
      check({nm, "/ack_pulse"}, 32'(ack[g]), 32'd0);
    end
  endtask

  initial begin
    int seen;
    bit pk, kp;
    logic w;
    logic [3:0] m;
    logic [5:0] idx;
    logic [1:0] off;
    logic [23:0] hi;
    rst_n = 1'b0;
    req = '0; wr = '0; addr = '0; mask = '0; dbus = '0;
    last_load[0] = '0; last_load[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      check($sformatf("reset%0d/ack", g), 32'(ack[g]), 32'd0);
      check($sformatf("reset%0d/err", g), 32'(err[g]), 32'd0);
      check($sformatf("reset%0d/data_out", g), dout[g], 32'd0);
      check($sformatf("reset%0d/mem_addr", g), 32'(maddr[g]), 32'd0);
      check($sformatf("reset%0d/rd_en", g), 32'(rd_en[g]), 32'd0);
      check($sformatf("reset%0d/wr_en", g), 32'(wr_en[g]), 32'd0);
      check($sformatf("reset%0d/wr_data", g), wr_data[g], 32'd0);
    end
    for (int g = 0; g < 2; g++)
      for (int i = 0; i < 64; i++) preload(g, i, $urandom);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    preload(0, 4, 32'hAABBCCDD);
    run_txn("byte_store", 0, 1'b1, 32'h12, 4'b0001, 32'h000000EE, 0, 0);
    check("byte_store/const", ram_word(0, 4), 32'hAAEECCDD);
    preload(0, 5, 32'h11223344);
    run_txn("half_load", 0, 1'b0, 32'h16, 4'b0011, 32'h0, 0, 0);
    check("half_load/const", dout[0], 32'h00001122);
    run_txn("word_store", 0, 1'b1, 32'h20, 4'hF, 32'hDEADBEEF, 0, 0);
    preload(0, 9, 32'h01020304);
    run_txn("overflow", 0, 1'b1, 32'h27, 4'b0011, 32'h000055AA, 0, 0);
    check("overflow/const", ram_word(0, 9), 32'hAA020304);

    preload(1, 3, 32'hCAFEF00D);
    run_txn("b2b_load", 1, 1'b0, 32'h0C, 4'hF, 32'h0, 0, 1);
    run_txn("b2b_store", 1, 1'b1, 32'h0D, 4'b0001, 32'h00000099, 1, 0);
    run_txn("mask0_store", 1, 1'b1, 32'h10, 4'h0, 32'h12345678, 0, 0);

    // Abort a partial store while its write strobe is up.
    req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h21; mask[0] = 4'b0001; dbus[0] = 32'h77;
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(posedge clk);
      #1;
      if (wr_en[0]) seen = 1;
    end
    check("rst_mid/wr_seen", 32'(seen), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid/wr_en", 32'(wr_en[0]), 32'd0);
    check("rst_mid/rd_en", 32'(rd_en[0]), 32'd0);
    check("rst_mid/ack", 32'(ack[0]), 32'd0);
    check("rst_mid/data_out", dout[0], 32'd0);
    req[0] = 1'b0;
    #2 rst_n = 1'b1;
    last_load[0] = '0; last_load[1] = '0;
    @(posedge clk);
    #1;
    check("rst_mid/ram_kept", ram_word(0, 8), gold[0][8]);
    run_txn("rst_mid/idle", 0, 1'b1, 32'h40, 4'h0, 32'h0, 0, 0);

    pk = 1'b0;
    for (int g = 0; g < 2; g++) begin
      for (int n = 0; n < 30; n++) begin
        w   = 1'($urandom_range(0, 1));
        idx = 6'($urandom_range(0, 63));
        off = 2'($urandom_range(0, 3));
        hi  = 24'($urandom);
        case ($urandom_range(0, 4))
          0:       m = 4'b0001;
          1:       m = 4'b0011;
          2:       m = 4'b1111;
          3:       m = 4'b0000;
          default: m = 4'($urandom_range(0, 15));
        endcase
        if ($urandom_range(0, 3) == 0) off = 2'b00;
        kp = (n != 29) && ($urandom_range(0, 3) == 0);
        run_txn($sformatf("rnd%0d_%0d", g, n), g, w, {hi, idx, off}, m, $urandom,
                pk ? 1 : 0, kp);
        pk = kp;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
